// File: rtl/dot_accum.sv
`default_nettype none
// ============================================================================
// dot_accum : sums CHUNKS dot-product results per output element and queues
// finished elements in a FWFT ready/valid FIFO. Macro DOT_ACCUM_SAT_EN: saturate.
// Revision  : 1.0
// ============================================================================
module dot_accum #(
  parameter int IWIDTH     = 32,
  parameter int OWIDTH     = 32,
  parameter int CHUNKS     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ivalid,
  input  logic [IWIDTH-1:0]                 idata,
  output logic                              ovalid,
  output logic [OWIDTH-1:0]                 odata,
  input  logic                              oready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   ocount,
  output logic                              overflow
);

  localparam int CNT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  generate
    if (OWIDTH < IWIDTH) begin : g_bad_width
      $error("dot_accum: OWIDTH must be >= IWIDTH");
    end
    if (CHUNKS < 1) begin : g_bad_chunks
      $error("dot_accum: CHUNKS must be >= 1");
    end
    if (FIFO_DEPTH < 2) begin : g_bad_depth
      $error("dot_accum: FIFO_DEPTH must be >= 2");
    end
  endgenerate

  logic [OWIDTH-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [OWIDTH-1:0] w_ext;
  logic [OWIDTH-1:0] w_add;
  logic [OWIDTH-1:0] w_sum;
  logic              w_last;
  logic              w_push_req;

  assign w_ext = OWIDTH'($signed(idata));

`ifdef DOT_ACCUM_SAT_EN
  // One guard bit: the top two bits differing means the signed add overflowed.
  logic [OWIDTH:0] w_wide;
  assign w_wide = {r_acc[OWIDTH-1], r_acc} + {w_ext[OWIDTH-1], w_ext};

  always_comb begin
    w_add = w_wide[OWIDTH-1:0];
    if (w_wide[OWIDTH] != w_wide[OWIDTH-1]) begin
      w_add = w_wide[OWIDTH] ? {1'b1, {(OWIDTH-1){1'b0}}}
                             : {1'b0, {(OWIDTH-1){1'b1}}};
    end
  end
`else
  assign w_add = r_acc + w_ext;
`endif

  assign w_sum      = (r_cnt == '0) ? w_ext : w_add;
  assign w_last     = (r_cnt == CNT_W'(CHUNKS - 1));
  assign w_push_req = ivalid && w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (ivalid) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  logic [OWIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_count;
  logic              r_overflow;
  logic              w_pop;
  logic              w_push;
  logic              w_full;

  assign ovalid   = (r_count != '0);
  assign odata    = ovalid ? r_mem[r_rd_ptr] : '0;
  assign ocount   = r_count;
  assign overflow = r_overflow;

  assign w_full = (r_count == OCC_W'(FIFO_DEPTH));
  assign w_pop  = ovalid && oready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dot_accum.sv
`default_nettype none
// ============================================================================
// tb_dot_accum : directed scoreboard bench for dot_accum (default parameters).
// Revision     : 1.0
// ============================================================================
module tb_dot_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ivalid = 1'b0;
  logic [31:0] idata = '0;
  logic        ovalid;
  logic [31:0] odata;
  logic        oready = 1'b0;
  logic [2:0]  ocount;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int popped = 0;
  logic [31:0] sb[$];

  dot_accum #(.IWIDTH(32), .OWIDTH(32), .CHUNKS(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ivalid(ivalid), .idata(idata),
    .ovalid(ovalid), .odata(odata), .oready(oready),
    .ocount(ocount), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head element must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && ovalid && oready) begin
      popped++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got 0x%08h expected no output", odata);
      end else begin
        chk("sb_odata", odata, sb.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] v);
    idata  = v;
    ivalid = 1'b1;
    @(posedge clk);
    #1;
    ivalid = 1'b0;
    idata  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic group_of(input logic [31:0] v, input logic [31:0] exp, input bit expect_out);
    send(v); send(v); send(v);
    if (expect_out) sb.push_back(exp);
    send(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    idle(2);
    @(negedge clk);
    chk("rst_ovalid", {31'd0, ovalid}, 32'd0);
    chk("rst_odata", odata, 32'd0);
    chk("rst_ocount", {29'd0, ocount}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: back-to-back 1..4, single-cycle output of 10
    oready = 1'b1;
    send(1); send(2); send(3);
    sb.push_back(32'd10);
    send(4);
    @(negedge clk);
    chk("t1_ovalid_hi", {31'd0, ovalid}, 32'd1);
    chk("t1_odata", odata, 32'd10);
    @(negedge clk);
    chk("t1_ovalid_lo", {31'd0, ovalid}, 32'd0);
    chk("t1_odata_idle", odata, 32'd0);
    chk("t1_ocount", {29'd0, ocount}, 32'd0);

    // 2: signed mix
    @(posedge clk); #1;
    send(-5); send(3); send(-7);
    sb.push_back(32'hFFFF_FFF9);
    send(2);
    idle(2);
    chk("t2_overflow", {31'd0, overflow}, 32'd0);

    // 3: 1..8 with random gaps
    p0 = popped;
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) sb.push_back(32'd10);
      if (i == 8) sb.push_back(32'd26);
      send(32'(i));
      idle($urandom_range(0, 3));
    end
    idle(3);
    chk("t3_outputs", 32'(popped - p0), 32'd2);

    // 4: overflow with stalled consumer
    do_reset();
    oready = 1'b0;
    p0 = popped;
    for (int g = 0; g < 4; g++) group_of(32'd1, 32'd4, 1'b1);
    @(negedge clk);
    chk("t4_ocount_full", {29'd0, ocount}, 32'd4);
    chk("t4_overflow_pre", {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    group_of(32'd1, 32'd4, 1'b0);
    @(negedge clk);
    chk("t4_overflow_set", {31'd0, overflow}, 32'd1);
    chk("t4_ocount_still", {29'd0, ocount}, 32'd4);
    @(posedge clk); #1;
    oready = 1'b1;
    idle(6);
    chk("t4_drained", 32'(popped - p0), 32'd4);
    chk("t4_ocount_empty", {29'd0, ocount}, 32'd0);
    chk("t4_overflow_sticky", {31'd0, overflow}, 32'd1);

    // 5: push into full FIFO with simultaneous pop
    do_reset();
    chk("t5_overflow_clr", {31'd0, overflow}, 32'd0);
    oready = 1'b0;
    p0 = popped;
    for (int g = 0; g < 4; g++) group_of(32'd1, 32'd4, 1'b1);
    send(2); send(2); send(2);
    sb.push_back(32'd8);
    oready = 1'b1;
    send(2);
    @(negedge clk);
    chk("t5_ocount", {29'd0, ocount}, 32'd4);
    chk("t5_overflow", {31'd0, overflow}, 32'd0);
    idle(8);
    chk("t5_drained", 32'(popped - p0), 32'd5);
    chk("t5_overflow_end", {31'd0, overflow}, 32'd0);

    // 6: reset mid-group discards the partial sum
    p0 = popped;
    send(100); send(200);
    do_reset();
    group_of(32'd1, 32'd4, 1'b1);
    idle(4);
    chk("t6_outputs", 32'(popped - p0), 32'd1);

    // Wrap (or saturation) at the positive and negative limits
`ifdef DOT_ACCUM_SAT_EN
    sb.push_back(32'h7FFF_FFFF);
`else
    sb.push_back(32'h8000_0004);
`endif
    send(32'h7FFF_FFFF); send(5); send(0); send(0);
`ifdef DOT_ACCUM_SAT_EN
    sb.push_back(32'h8000_0000);
`else
    sb.push_back(32'h7FFF_FFFF);
`endif
    send(32'h8000_0000); send(32'hFFFF_FFFF); send(0); send(0);
    idle(4);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dot_accum.md
Name: dot_accum

Overview:
- Downstream of the 8-lane dot-product stage in the matrix-vector multiplier.
- Sums CHUNKS consecutive dot-product results, each covering 8 lanes, into one output element of the result vector. One element is one matrix row times the vector.
- Completed elements go into a small first-word-fall-through FIFO with a ready/valid output. This decouples the free-running dot pipeline, which has no backpressure, from the consumer, which may stall.

Parameters:
- IWIDTH, 32, width of incoming signed dot-product result.
- OWIDTH, 32, width of accumulated signed output element; must be >= IWIDTH.
- CHUNKS, 4, dot results summed per output element; must be >= 1.
- FIFO_DEPTH, 4, output FIFO entries; must be >= 2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ivalid  input  1  idata valid this cycle; always accepted, no ready.
- idata  input  IWIDTH  signed dot-product result.
- ovalid  output  1  FIFO head valid.
- odata  output  OWIDTH  signed FIFO head element; 0 when ovalid=0.
- oready  input  1  consumer accepts head this cycle.
- ocount  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- overflow  output  1  sticky: a completed element was dropped.

Behaviour:

Reset:
- Synchronous, active-high reset on rst; clock clk.
- Reset clears acc and cnt to 0 and empties the FIFO.
- Output reset values: ovalid=0, odata=0, ocount=0, overflow=0.
- Reset mid-group discards the partial sum. The next accepted input is chunk 0.

Accumulation (on each cycle with ivalid=1):
- ext = idata sign-extended to OWIDTH.
- sum = (cnt==0) ? ext : acc + ext. Arithmetic is modulo 2^OWIDTH (wraps).
- If cnt == CHUNKS-1: sum is the completed element; request a push; cnt <= 0.
- Otherwise: acc <= sum; cnt <= cnt+1.
- ivalid=0: acc and cnt hold. Gaps between chunks of any length are allowed.
- CHUNKS=1: every valid input is a completed element.

FIFO:
- Circular buffer with read and write pointers that wrap at FIFO_DEPTH, plus an occupancy counter.
- pop = ovalid && oready.
- push succeeds if ocount < FIFO_DEPTH, or if the FIFO is full and pop happens in the same cycle.
- Push and pop in the same cycle: ocount unchanged, both pointers advance.
- Full, no pop, push requested: element dropped; overflow <= 1 and stays set until rst. Accumulation continues normally.
- oready while empty: no effect.
- ovalid = (ocount != 0). odata = head entry when ovalid=1, else 0.

Latency:
- An element completed in cycle N (last chunk sampled at edge N) is visible with ovalid=1 after edge N, i.e. during cycle N+1, when the FIFO was empty.
- Sustained throughput: one element per CHUNKS valid inputs. A FIFO never drains slower than oready permits.

Optional Feature:
- Macro: DOT_ACCUM_SAT_EN.
- Defined: every addition acc + ext saturates to the OWIDTH signed range [-2^(OWIDTH-1), 2^(OWIDTH-1)-1]. Saturation is applied per chunk, before storing to acc or pushing.
- Not defined: plain two's-complement wrap, as described under Behaviour.
- Check with the macro defined (OWIDTH=IWIDTH=32, CHUNKS=2): inputs 0x7FFFFFFF, 5 -> output 0x7FFFFFFF. Without the macro, the same inputs -> 0x80000004.

Test Plan:
1. After rst, oready=1, inputs 1,2,3,4 back-to-back -> ovalid high for exactly 1 cycle, the cycle after the 4th input, odata=10; ocount returns to 0.
2. Inputs -5,3,-7,2 -> odata=-7 (0xFFFFFFF9); overflow stays 0.
3. Inputs 1..8 with 0-3 idle cycles randomly inserted between them, oready=1 -> exactly two outputs, 10 then 26, in order.
4. oready=0, five groups of four inputs of 1 -> ocount=4 after the 4th group; overflow=1 one cycle after the 5th group completes. Then oready=1 drains exactly four values of 4, and overflow remains 1.
5. FIFO full (4 entries), oready=1 in the same cycle a 5th element completes with value 8 -> no overflow, ocount stays 4, the 8 emerges after the existing entries.
6. Two chunks (100,200) fed, rst pulsed 1 cycle, then 1,1,1,1 -> single output 4; no element containing 300 is ever emitted.
